// File: rtl/endtask_dut.sv
// Purpose: answers scoped name lookups (outer scope vs. inner blk scope), with T-call counters and a writable inner w.
// Latency: one cycle; a request taken at an edge responds in the cycle that edge starts.
// Backpressure: none; one request can be taken every cycle, and responses come out in order.
module endtask_dut #(
    parameter logic [3:0] P_OUT      = 4'd1,
    parameter logic [3:0] L_OUT      = 4'd2,
    parameter logic [3:0] W_OUT      = 4'd3,
    parameter logic [3:0] F_OUT      = 4'hF,
    parameter logic [3:0] P_BLK      = 4'd4,
    parameter logic [3:0] L_BLK      = 4'd6,
    parameter logic [3:0] W_BLK_INIT = 4'd7,
    parameter logic [3:0] F_BLK      = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_scope,
    input  logic [2:0] req_item,
    input  logic       req_arg,
    input  logic [3:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    output logic       resp_err,
    output logic       t_called,
    output logic       t_scope,
    output logic [7:0] t_cnt_out,
    output logic [7:0] t_cnt_blk
);

    typedef enum logic [2:0] {
        ITEM_P   = 3'd0,
        ITEM_L   = 3'd1,
        ITEM_W   = 3'd2,
        ITEM_X   = 3'd3,
        ITEM_F   = 3'd4,
        ITEM_T   = 3'd5,
        ITEM_WR  = 3'd6,
        ITEM_RSV = 3'd7
    } item_e;

    logic       resp_valid_q, resp_valid_d;
    logic [7:0] resp_data_q,  resp_data_d;
    logic       resp_err_q,   resp_err_d;
    logic       t_called_q,   t_called_d;
    logic       t_scope_q,    t_scope_d;
    logic [7:0] t_cnt_out_q,  t_cnt_out_d;
    logic [7:0] t_cnt_blk_q,  t_cnt_blk_d;
    logic [3:0] blk_w_q,      blk_w_d;

    // The function argument has no effect on F's return value.
    logic unused_arg;
    assign unused_arg = req_arg;

    // Saturating counter increments. A T call at 255 still counts as a successful call.
    logic [7:0] cnt_out_inc;
    logic [7:0] cnt_blk_inc;
    assign cnt_out_inc = (t_cnt_out_q == 8'hFF) ? t_cnt_out_q : t_cnt_out_q + 8'd1;
    assign cnt_blk_inc = (t_cnt_blk_q == 8'hFF) ? t_cnt_blk_q : t_cnt_blk_q + 8'd1;

    // Resolve the request. Inner names shadow outer ones and never fall back; x exists only in the outer scope.
    always_comb begin
        resp_valid_d = req_valid;
        resp_data_d  = 8'd0;
        resp_err_d   = 1'b0;
        t_called_d   = 1'b0;
        t_scope_d    = t_scope_q;
        t_cnt_out_d  = t_cnt_out_q;
        t_cnt_blk_d  = t_cnt_blk_q;
        blk_w_d      = blk_w_q;
        if (req_valid) begin
            case (item_e'(req_item))
                ITEM_P: resp_data_d = req_scope ? {4'd0, P_BLK} : {4'd0, P_OUT};
                ITEM_L: resp_data_d = req_scope ? {4'd0, L_BLK} : {4'd0, L_OUT};
                ITEM_W: resp_data_d = req_scope ? {4'd0, blk_w_q} : {4'd0, W_OUT};
                ITEM_X: begin
                    if (req_scope) begin
                        resp_err_d = 1'b1;
                    end else begin
                        resp_data_d = {4'd0, W_OUT} + 8'd1;
                    end
                end
                ITEM_F: resp_data_d = req_scope ? {4'd0, F_BLK} : {4'd0, F_OUT};
                ITEM_T: begin
                    t_called_d = 1'b1;
                    t_scope_d  = req_scope;
                    if (req_scope) begin
                        t_cnt_blk_d = cnt_blk_inc;
                        resp_data_d = cnt_blk_inc;
                    end else begin
                        t_cnt_out_d = cnt_out_inc;
                        resp_data_d = cnt_out_inc;
                    end
                end
                ITEM_WR: begin
                    // Outer w is a constant, so a write to it is rejected.
                    if (req_scope) begin
                        blk_w_d     = req_wdata;
                        resp_data_d = {4'd0, req_wdata};
                    end else begin
                        resp_err_d = 1'b1;
                    end
                end
                ITEM_RSV: resp_err_d = 1'b1;
            endcase
        end
    end

    // State and response registers. Reset discards any request arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= 8'd0;
            resp_err_q   <= 1'b0;
            t_called_q   <= 1'b0;
            t_scope_q    <= 1'b0;
            t_cnt_out_q  <= 8'd0;
            t_cnt_blk_q  <= 8'd0;
            blk_w_q      <= W_BLK_INIT;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            t_called_q   <= t_called_d;
            t_scope_q    <= t_scope_d;
            t_cnt_out_q  <= t_cnt_out_d;
            t_cnt_blk_q  <= t_cnt_blk_d;
            blk_w_q      <= blk_w_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign t_called   = t_called_q;
    assign t_scope    = t_scope_q;
    assign t_cnt_out  = t_cnt_out_q;
    assign t_cnt_blk  = t_cnt_blk_q;

endmodule

// File: tb/tb_endtask_dut.sv
// Bench for endtask_dut: table-driven lookups plus hand-written T-call, write, saturation and reset sequences.
// Expected responses are queued when a request is driven and compared when the response appears.
// Outputs are sampled 1 time unit after each rising edge; inputs change on falling edges.
module tb_endtask_dut;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_scope;
    logic [2:0] req_item;
    logic       req_arg;
    logic [3:0] req_wdata;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       resp_err;
    logic       t_called;
    logic       t_scope;
    logic [7:0] t_cnt_out;
    logic [7:0] t_cnt_blk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       scope;
        logic [2:0] item;
        logic [3:0] wdata;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic       tcall;
        logic       tscope;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    vec_t vecs[12];

    always #5 clk = ~clk;

    endtask_dut dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_scope  (req_scope),
        .req_item   (req_item),
        .req_arg    (req_arg),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .t_called   (t_called),
        .t_scope    (t_scope),
        .t_cnt_out  (t_cnt_out),
        .t_cnt_blk  (t_cnt_blk)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one request on the falling edge and queue its expected response.
    task automatic send(input logic s, input logic [2:0] it, input logic [3:0] wd,
                        input logic [7:0] ed, input logic ee, input logic et);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_scope = s;
        req_item  = it;
        req_wdata = wd;
        req_arg   = 1'($urandom_range(0, 1));
        e.data   = ed;
        e.err    = ee;
        e.tcall  = et;
        e.tscope = s;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Scoreboard: each sample must carry a response exactly when one is queued.
    always @(posedge clk) begin
        #1;
        chk("resp_valid", 32'(resp_valid), 32'(exp_q.size() != 0));
        if (resp_valid && exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("resp_data", 32'(resp_data), 32'(cur.data));
            chk("resp_err", 32'(resp_err), 32'(cur.err));
            chk("t_called", 32'(t_called), 32'(cur.tcall));
            if (cur.tcall) chk("t_scope", 32'(t_scope), 32'(cur.tscope));
        end else if (!resp_valid) begin
            chk("idle_data", 32'(resp_data), 32'd0);
            chk("idle_err", 32'(resp_err), 32'd0);
            chk("idle_t_called", 32'(t_called), 32'd0);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    initial begin
        vecs[0]  = '{1'b0, 3'd0, 4'd0, 8'd1,  1'b0};
        vecs[1]  = '{1'b0, 3'd1, 4'd0, 8'd2,  1'b0};
        vecs[2]  = '{1'b0, 3'd2, 4'd0, 8'd3,  1'b0};
        vecs[3]  = '{1'b0, 3'd3, 4'd0, 8'd4,  1'b0};
        vecs[4]  = '{1'b0, 3'd4, 4'd0, 8'd15, 1'b0};
        vecs[5]  = '{1'b1, 3'd0, 4'd0, 8'd4,  1'b0};
        vecs[6]  = '{1'b1, 3'd1, 4'd0, 8'd6,  1'b0};
        vecs[7]  = '{1'b1, 3'd2, 4'd0, 8'd7,  1'b0};
        vecs[8]  = '{1'b1, 3'd4, 4'd0, 8'd8,  1'b0};
        vecs[9]  = '{1'b1, 3'd3, 4'd0, 8'd0,  1'b1};
        vecs[10] = '{1'b0, 3'd7, 4'd5, 8'd0,  1'b1};
        vecs[11] = '{1'b1, 3'd7, 4'd5, 8'd0,  1'b1};

        // Reset with an inner T request pending: it must be discarded.
        rst = 1'b1;
        req_valid = 1'b1;
        req_scope = 1'b1;
        req_item  = 3'd5;
        req_arg   = 1'b0;
        req_wdata = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_t_called", 32'(t_called), 32'd0);
        chk("rst_t_scope", 32'(t_scope), 32'd0);
        chk("rst_t_cnt_out", 32'(t_cnt_out), 32'd0);
        chk("rst_t_cnt_blk", 32'(t_cnt_blk), 32'd0);
        rst = 1'b0;
        req_valid = 1'b0;

        // Scope lookups, including shadowing, the missing inner x and the reserved item.
        for (int i = 0; i < 12; i++)
            send(vecs[i].scope, vecs[i].item, vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_err, 1'b0);
        idle();

        // Two outer T calls, then one inner T call.
        send(1'b0, 3'd5, 4'd0, 8'd1, 1'b0, 1'b1);
        send(1'b0, 3'd5, 4'd0, 8'd2, 1'b0, 1'b1);
        send(1'b1, 3'd5, 4'd0, 8'd1, 1'b0, 1'b1);
        idle();
        chk("t_cnt_out_after_calls", 32'(t_cnt_out), 32'd2);
        chk("t_cnt_blk_after_calls", 32'(t_cnt_blk), 32'd1);

        // Inner write read back-to-back; outer write rejected and outer w unchanged.
        send(1'b1, 3'd6, 4'hA, 8'h0A, 1'b0, 1'b0);
        send(1'b1, 3'd2, 4'd0, 8'h0A, 1'b0, 1'b0);
        send(1'b0, 3'd6, 4'h5, 8'd0,  1'b1, 1'b0);
        send(1'b0, 3'd2, 4'd0, 8'd3,  1'b0, 1'b0);
        send(1'b1, 3'd2, 4'd0, 8'h0A, 1'b0, 1'b0);
        idle();

        // Inner counter saturation: it starts at 1 here.
        for (int i = 0; i < 256; i++)
            send(1'b1, 3'd5, 4'd0, ((i + 2) > 255) ? 8'd255 : 8'(i + 2), 1'b0, 1'b1);
        idle();
        chk("t_cnt_blk_saturated", 32'(t_cnt_blk), 32'd255);
        chk("t_cnt_out_untouched", 32'(t_cnt_out), 32'd2);

        // Mid-stream reset with a request in the same cycle: no response, state back to reset values.
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b1;
        req_scope = 1'b1;
        req_item  = 3'd6;
        req_wdata = 4'h3;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        chk("mid_rst_t_cnt_out", 32'(t_cnt_out), 32'd0);
        chk("mid_rst_t_cnt_blk", 32'(t_cnt_blk), 32'd0);
        chk("mid_rst_t_scope", 32'(t_scope), 32'd0);
        send(1'b1, 3'd2, 4'd0, 8'd7, 1'b0, 1'b0);
        send(1'b0, 3'd5, 4'd0, 8'd1, 1'b0, 1'b1);
        idle();
        chk("t_cnt_out_after_reset_call", 32'(t_cnt_out), 32'd1);

        repeat (2) idle();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
